bit_serializer: RTL and testbench
=================================

// Module: bit_serializer
// PURPOSE
//   Parallel-to-serial front end for the bit-stream DFA detectors.
//   - Accepts WIDTH-bit words over a valid/ready handshake.
//   - Emits each word MSB-first, one bit per clk, on serial_out.
//   - serial_out connects directly to a detector's input_sequence.
//   - A one-word holding register lets back-to-back words stream with no idle cycle.
// PARAMETERS
//   WIDTH  8  word width in bits; legal range WIDTH >= 2
// PORTS
//   clk           input   1      system clock; all state updates on posedge
//   reset         input   1      synchronous, active-low reset (0 = reset)
//   in_data       input   WIDTH  word to serialize; sampled when in_valid && in_ready
//   in_valid      input   1      upstream offers in_data
//   in_ready      output  1      holding register empty; word accepted this edge if in_valid
//   serial_out    output  1      current serial bit; 0 when serial_valid=0
//   serial_valid  output  1      serial_out carries a word bit this cycle
//   word_start    output  1      high only during the first (MSB) bit of each word
//   busy          output  1      serial_valid || holding register full
// BEHAVIOUR
//   - Reset (reset=0 at posedge):
//     - serial_out, serial_valid and word_start go to 0; holding register and shifter
//       are emptied; bit counter is cleared.
//     - in_ready=0 while reset=0; busy=0 after the reset edge.
//     - Reset asserted mid-word aborts the word immediately; no partial bits follow.
//   - Handshake:
//     - in_ready = reset && !hold_full.
//     - Accept on posedge when in_valid && in_ready; in_data is copied into hold.
//     - in_data/in_valid are ignored while in_ready=0; upstream holds the word.
//   - States: IDLE (shifter empty) and SHIFT (bit counter 0..WIDTH-1), plus PARITY
//     when BIT_SERIALIZER_PARITY_EN is defined.
//   - Load rule: hold moves to the shifter on the posedge where hold_full && (state==IDLE
//     || the last bit of the current word is being shown).
//     - At that edge: serial_out=MSB, serial_valid=1, word_start=1, counter=0, hold empties.
//   - Latency:
//     - Accept at edge E0 -> MSB visible after E1 -> LSB visible after E(WIDTH).
//     - Sustained throughput is one word per WIDTH cycles, with no gap between words.
//   - Shifting: each posedge in SHIFT shows the next lower bit; word_start=0 after the first bit.
//   - Last bit with hold empty: next edge -> IDLE, serial_valid=0, serial_out=0.
//   - Simultaneous events: the load of hold into the shifter and a new accept never occur
//     on the same edge, because in_ready was 0 while hold was full. The new accept is
//     possible from the following edge.
//   - All outputs are registered or derive only from registered state; no combinational
//     path from in_valid to in_ready.
// CONFIGURATION
//   BIT_SERIALIZER_PARITY_EN
//   - Defined:
//     - After the LSB, one extra cycle emits the even-parity bit (XOR of the word), with
//       serial_valid=1 and word_start=0.
//     - The load rule uses the parity cycle as the "last bit".
//     - Period is WIDTH+1 cycles per word.
//   - Undefined: no PARITY state; period is WIDTH cycles per word.
// TESTING
//   1. reset=0 for 3 cycles with in_valid=1, in_data=8'hFF
//      -> in_ready=0, serial_valid=0, serial_out=0; after release, nothing is emitted
//         until the next accept.
//   2. One word 8'b0010_1101 accepted at E0
//      -> after E1..E8 serial_out=0,0,1,0,1,1,0,1; serial_valid=1 for those 8 cycles;
//         word_start=1 only after E1; idle from E9.
//   3. 8'hA5 then 8'h3C with in_valid held high
//      -> 16 contiguous serial_valid cycles carrying 1010_0101_0011_1100;
//         word_start after E1 and E9; in_ready low while hold is full.
//   4. reset=0 for one edge after 3 bits of 8'hF0
//      -> next cycle all outputs 0 and hold empty; a new word 8'h81 restarts from its
//         MSB with the sequence 1,0,0,0,0,0,0,1.
//   5. 8'h07 with BIT_SERIALIZER_PARITY_EN defined
//      -> 9 valid bits 0000_0111 followed by parity 1.
//      Same stimulus with the macro undefined -> exactly 8 valid bits.
//   6. serial_out driving the two-last-bits-01 DFA, word 8'b0000_0101
//      -> condition_met pulses after the 6th and 8th bits.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and emits them MSB-first.
// Optional even-parity trailer bit per word when BIT_SERIALIZER_PARITY_EN is defined.
module bit_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             word_start,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef BIT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_d;
    logic [WIDTH-1:0] hold, hold_d;
    logic             hold_full, hold_full_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             sout, sout_d;
    logic             svalid, svalid_d;
    logic             wstart, wstart_d;
    logic             last_bit;
    logic             load;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             par, par_d;
`endif

    assign in_ready     = reset && !hold_full;
    assign serial_out   = sout;
    assign serial_valid = svalid;
    assign word_start   = wstart;
    assign busy         = svalid || hold_full;

    always_comb begin
        state_d     = state;
        hold_d      = hold;
        hold_full_d = hold_full;
        shreg_d     = shreg;
        cnt_d       = cnt;
        sout_d      = sout;
        svalid_d    = svalid;
        wstart_d    = wstart;
`ifdef BIT_SERIALIZER_PARITY_EN
        par_d       = par;
        last_bit    = (state == PARITY);
`else
        last_bit    = (state == SHIFT) && (cnt == LAST);
`endif
        load = hold_full && ((state == IDLE) || last_bit);

        // Accept and load are exclusive: in_ready is low whenever hold is full.
        if (in_valid && in_ready) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end

        if (load) begin
            state_d     = SHIFT;
            shreg_d     = hold;
            cnt_d       = '0;
            sout_d      = hold[WIDTH-1];
            svalid_d    = 1'b1;
            wstart_d    = 1'b1;
            hold_full_d = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_d       = ^hold;
`endif
        end else if (last_bit) begin
            state_d  = IDLE;
            sout_d   = 1'b0;
            svalid_d = 1'b0;
            wstart_d = 1'b0;
        end else if (state == SHIFT) begin
            wstart_d = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            if (cnt == LAST) begin
                state_d = PARITY;
                sout_d  = par;
            end else begin
                shreg_d = shreg << 1;
                sout_d  = shreg[WIDTH-2];
                cnt_d   = cnt + 1'b1;
            end
`else
            shreg_d = shreg << 1;
            sout_d  = shreg[WIDTH-2];
            cnt_d   = cnt + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            shreg     <= '0;
            cnt       <= '0;
            sout      <= 1'b0;
            svalid    <= 1'b0;
            wstart    <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            hold      <= hold_d;
            hold_full <= hold_full_d;
            shreg     <= shreg_d;
            cnt       <= cnt_d;
            sout      <= sout_d;
            svalid    <= svalid_d;
            wstart    <= wstart_d;
`ifdef BIT_SERIALIZER_PARITY_EN
            par       <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer (WIDTH=8), parity-aware via BIT_SERIALIZER_PARITY_EN.
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int P = 9;
`else
    localparam int P = 8;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready, serial_out, serial_valid, word_start, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .serial_out(serial_out), .serial_valid(serial_valid),
        .word_start(word_start), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        n_checks++;
        if (obs !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(serial_valid), 0);
        check({tag, "_out"},   32'(serial_out),   0);
        check({tag, "_start"}, 32'(word_start),   0);
        check({tag, "_busy"},  32'(busy),         0);
    endtask

    // Accept one word, then check every bit (plus parity when enabled) and the return to idle.
    task automatic send_word(input logic [7:0] w, input string tag);
        check({tag, "_ready"}, 32'(in_ready), 1);
        in_data  = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < P; i++) begin
            tick();
            check({tag, "_valid"}, 32'(serial_valid), 1);
            check({tag, "_bit"},   32'(serial_out), (i < 8) ? 32'(w[7-i]) : 32'(^w));
            check({tag, "_start"}, 32'(word_start), (i == 0) ? 1 : 0);
        end
        tick();
        check_idle({tag, "_end"});
    endtask

    initial begin
        logic [7:0] wd;
        logic       prev;
        logic       fire;

        // 1: reset held with a word offered
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ready", 32'(in_ready), 0);
            check_idle("rst");
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("post_rst");
        end

        // 2: single word
        send_word(8'b0010_1101, "w2d");

        // 3: back-to-back words with no gap
        in_data  = 8'hA5;
        in_valid = 1'b1;
        tick();
        in_data = 8'h3C;
        for (int k = 1; k <= 2 * P; k++) begin
            int idx;
            tick();
            idx = (k - 1) % P;
            wd  = (k <= P) ? 8'hA5 : 8'h3C;
            if (k == 1) check("b2b_ready_free", 32'(in_ready), 1);
            if (k == 2) begin
                check("b2b_ready_full", 32'(in_ready), 0);
                in_valid = 1'b0;
            end
            if (k == P) check("b2b_busy", 32'(busy), 1);
            check("b2b_valid", 32'(serial_valid), 1);
            check("b2b_bit",   32'(serial_out), (idx < 8) ? 32'(wd[7-idx]) : 32'(^wd));
            check("b2b_start", 32'(word_start), (idx == 0) ? 1 : 0);
        end
        tick();
        check_idle("b2b_end");

        // 4: reset mid-word aborts it
        in_data  = 8'hF0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_bit", 32'(serial_out), 1);
        end
        reset = 1'b0;
        tick();
        check("abort_ready", 32'(in_ready), 0);
        check_idle("abort");
        reset = 1'b1;
        #1;
        tick();
        check_idle("abort_after");
        send_word(8'h81, "w81");

        // 5: parity trailer or plain 8 bits depending on build
        send_word(8'h07, "w07");

        // 6: "last two bits 01" detector on the serial stream
        in_data  = 8'b0000_0101;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        prev = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            fire = serial_valid && !prev && serial_out;
            check("dfa_fire", 32'(fire), (i == 5 || i == 7) ? 1 : 0);
            prev = serial_out;
        end
        repeat (P - 7) tick();
        check_idle("dfa_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
